// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding, watchdog
// sizing and a small helper for index widths.
package counter_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    // Watchdog counter width and the WAIT-cycle count that trips it.
    localparam int WDOG_W     = 6;
    localparam int WDOG_LIMIT = 40;

    // Width of a requester index; at least one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit
// strictly after ptr, wrapping around, so ptr itself has lowest priority.
module counter_arbiter_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] pos_s;

    // Walk positions ptr+1 .. ptr+NREQ (mod NREQ) and keep the first hit.
    always_comb begin
        pick  = '0;
        idx   = '0;
        any   = 1'b0;
        sum_s = '0;
        pos_s = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum_s = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum_s >= (IDX_W+1)'(NREQ)) begin
                pos_s = IDX_W'(sum_s - (IDX_W+1)'(NREQ));
            end else begin
                pos_s = IDX_W'(sum_s);
            end
            if (!any && req[pos_s]) begin
                pick[pos_s] = 1'b1;
                idx         = pos_s;
                any         = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter sharing one up_counter between NREQ requesters.
// The granted requester's value is loaded, the arbiter waits for the
// terminal flag, pulses done and releases the counter.
// Optional watchdog: define COUNTER_ARB_TIMEOUT_EN to abort a WAIT that
// sees no terminal flag within the limit and raise a sticky err.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int VAL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*VAL_W-1:0] req_val,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic                  err,
    output logic [VAL_W-1:0]      cnt_val,
    output logic                  cnt_load,
    input  logic                  cnt_r
);

    localparam int IDX_W = idx_width(NREQ);

    arb_state_e       state_r;
    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] idx_r;
    logic [NREQ-1:0]  gnt_r;
    logic [NREQ-1:0]  done_r;
    logic             busy_r;
    logic [VAL_W-1:0] cnt_val_r;
    logic             cnt_load_r;

    logic [NREQ-1:0]  pick_s;
    logic [IDX_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic [VAL_W-1:0] sel_val_s;
    logic             req_held_s;

`ifdef COUNTER_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog_r;
    logic              err_r;
`endif

    counter_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (req),
        .ptr  (rr_ptr_r),
        .pick (pick_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    // Select the load value belonging to the requester the picker chose.
    always_comb begin
        sel_val_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_idx_s == IDX_W'(i)) begin
                sel_val_s = req_val[i*VAL_W +: VAL_W];
            end else begin
                sel_val_s = sel_val_s;
            end
        end
    end

    // The granted requester still holds its request (gnt_r is one-hot).
    assign req_held_s = |(req & gnt_r);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            rr_ptr_r   <= IDX_W'(NREQ - 1);
            idx_r      <= '0;
            gnt_r      <= '0;
            done_r     <= '0;
            busy_r     <= 1'b0;
            cnt_val_r  <= '0;
            cnt_load_r <= 1'b0;
`ifdef COUNTER_ARB_TIMEOUT_EN
            wdog_r     <= '0;
            err_r      <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= '0;
                    if (pick_any_s) begin
                        state_r    <= LOAD;
                        idx_r      <= pick_idx_s;
                        gnt_r      <= pick_s;
                        cnt_val_r  <= sel_val_s;
                        cnt_load_r <= 1'b1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= IDLE;
                        gnt_r      <= '0;
                        cnt_load_r <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                // cnt_r may be stale from the previous count; ignore it here.
                LOAD: begin
                    cnt_load_r <= 1'b0;
                    state_r    <= WAIT;
`ifdef COUNTER_ARB_TIMEOUT_EN
                    wdog_r     <= '0;
`endif
                end
                // Abort takes priority over a simultaneous terminal flag.
                WAIT: begin
                    if (!req_held_s) begin
                        state_r  <= IDLE;
                        gnt_r    <= '0;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= idx_r;
                    end else if (cnt_r) begin
                        state_r <= DONE;
                        done_r  <= gnt_r;
`ifdef COUNTER_ARB_TIMEOUT_EN
                    end else if (wdog_r == WDOG_W'(WDOG_LIMIT - 1)) begin
                        state_r  <= IDLE;
                        gnt_r    <= '0;
                        busy_r   <= 1'b0;
                        rr_ptr_r <= idx_r;
                        err_r    <= 1'b1;
                    end else begin
                        wdog_r <= wdog_r + WDOG_W'(1);
                    end
`else
                    end else begin
                        state_r <= WAIT;
                    end
`endif
                end
                DONE: begin
                    state_r  <= IDLE;
                    done_r   <= '0;
                    gnt_r    <= '0;
                    busy_r   <= 1'b0;
                    rr_ptr_r <= idx_r;
                end
                default: begin
                    state_r    <= IDLE;
                    gnt_r      <= '0;
                    done_r     <= '0;
                    busy_r     <= 1'b0;
                    cnt_load_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign busy     = busy_r;
    assign cnt_val  = cnt_val_r;
    assign cnt_load = cnt_load_r;
`ifdef COUNTER_ARB_TIMEOUT_EN
    assign err      = err_r;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter (NREQ=4, VAL_W=4): a vector table of
// back-to-back grants plus hand-written multi-cycle sequences.
module tb_counter_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] req_val;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        err;
    logic [3:0]  cnt_val;
    logic        cnt_load;
    logic        cnt_r;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] vals;
        int          exp_idx;
        logic [3:0]  exp_val;
        int          rdly;
    } vec_t;

    vec_t tbl [9];

    // Free-running clock.
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL sim_timeout: bench did not finish in time");
        $fatal(1);
    end

    counter_arbiter #(.NREQ(4), .VAL_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_val  (req_val),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .cnt_val  (cnt_val),
        .cnt_load (cnt_load),
        .cnt_r    (cnt_r)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wait for the load, check it, then wait rdly cycles and pulse cnt_r.
    task automatic serve(input int ei, input logic [3:0] ev, input int rdly);
        int lat;
        logic [3:0] oh;
        oh  = 4'b0001 << ei;
        lat = 0;
        while (cnt_load !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        check("load_latency", lat, 1);
        check("load_gnt", gnt, oh);
        check("load_val", cnt_val, ev);
        check("load_busy", busy, 1);
        repeat (rdly) tick();
        check("wait_no_load", cnt_load, 0);
        check("wait_no_done", done, 0);
        check("wait_gnt", gnt, oh);
        cnt_r = 1'b1;
        tick();
        check("done_pulse", done, oh);
        check("done_gnt", gnt, oh);
        cnt_r = 1'b0;
    endtask

    // Present the next request set during DONE, then check the release cycle.
    task automatic release_chk(input logic [3:0] nreq, input logic [15:0] nval);
        req     = nreq;
        req_val = nval;
        tick();
        check("rel_done", done, 0);
        check("rel_gnt", gnt, 0);
        check("rel_busy", busy, 0);
    endtask

    initial begin
        int k;
        tbl[0] = '{4'b1111, 16'h4321, 0, 4'd1, 2};
        tbl[1] = '{4'b1111, 16'h4321, 1, 4'd2, 1};
        tbl[2] = '{4'b1111, 16'h4321, 2, 4'd3, 3};
        tbl[3] = '{4'b1111, 16'h4321, 3, 4'd4, 1};
        tbl[4] = '{4'b1111, 16'h4321, 0, 4'd1, 2};
        tbl[5] = '{4'b0101, 16'h4321, 2, 4'd3, 1};
        tbl[6] = '{4'b0101, 16'h4321, 0, 4'd1, 1};
        tbl[7] = '{4'b0010, 16'h00F0, 1, 4'hF, 1};
        tbl[8] = '{4'b0001, 16'h0006, 0, 4'd6, 10};

        rst_n = 1'b0; req = 4'b0000; req_val = 16'h0000; cnt_r = 1'b0;
        repeat (2) tick();
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_load", cnt_load, 0);
        check("rst_val", cnt_val, 0);
        rst_n = 1'b1;
        tick();

        // Table: contention 0,1,2,3,0, fairness 2 then 0, then single requests.
        req = tbl[0].req; req_val = tbl[0].vals;
        for (int i = 0; i < 9; i++) begin
            serve(tbl[i].exp_idx, tbl[i].exp_val, tbl[i].rdly);
            if (i < 8) release_chk(tbl[i+1].req, tbl[i+1].vals);
            else       release_chk(4'b0000, 16'h0000);
        end

        // Abort: drop req[1] mid-WAIT; a later cnt_r must be ignored.
        req = 4'b0010; req_val = 16'h0050;
        tick();
        check("ab_gnt", gnt, 4'b0010);
        check("ab_val", cnt_val, 5);
        tick(); tick();
        req = 4'b0000;
        tick();
        check("ab_gnt_clr", gnt, 0);
        check("ab_no_done", done, 0);
        check("ab_busy", busy, 0);
        cnt_r = 1'b1;
        tick();
        check("ab_late_r_load", cnt_load, 0);
        check("ab_late_r_done", done, 0);
        tick();
        check("ab_late_r_done2", done, 0);
        check("ab_late_r_gnt", gnt, 0);
        cnt_r = 1'b0;

        // Abort and cnt_r in the same cycle: abort wins.
        req = 4'b0100; req_val = 16'h0700;
        tick();
        check("aw_gnt", gnt, 4'b0100);
        tick();
        req = 4'b0000; cnt_r = 1'b1;
        tick();
        check("aw_gnt_clr", gnt, 0);
        check("aw_no_done", done, 0);
        cnt_r = 1'b0;
        tick();
        check("aw_no_done2", done, 0);

        // Stale R held through LOAD; done only after the later pulse.
        req = 4'b0001; req_val = 16'h0006;
        tick();
        check("st_load", cnt_load, 1);
        check("st_gnt", gnt, 4'b0001);
        cnt_r = 1'b1;
        tick();
        check("st_no_done", done, 0);
        cnt_r = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("st_wait_no_done", done, 0);
        end
        cnt_r = 1'b1;
        tick();
        check("st_done", done, 4'b0001);
        cnt_r = 1'b0; req = 4'b0000;
        tick();
        check("st_rel_gnt", gnt, 0);

        // Long WAIT without cnt_r.
        req = 4'b0010; req_val = 16'h0030;
        tick();
        check("wd_gnt", gnt, 4'b0010);
`ifdef COUNTER_ARB_TIMEOUT_EN
        k = 0;
        while (gnt !== 4'b0000 && k < 60) begin
            tick();
            k++;
            if (done !== 4'b0000) check("wd_no_done", done, 0);
        end
        check("wd_cycles_in_range", (k >= 40 && k <= 42), 1);
        check("wd_err", err, 1);
        check("wd_busy", busy, 0);
        req = 4'b0000;
        tick();
        check("wd_err_sticky", err, 1);
`else
        k = 0;
        repeat (45) begin
            tick();
            k++;
        end
        check("wd_still_gnt", gnt, 4'b0010);
        check("wd_err_zero", err, 0);
        check("wd_no_done", done, 0);
        cnt_r = 1'b1;
        tick();
        check("wd_done", done, 4'b0010);
        cnt_r = 1'b0; req = 4'b0000;
        tick();
        check("wd_rel_gnt", gnt, 0);
`endif

        // Reset mid-WAIT; afterwards req[0] wins over req[3].
        req = 4'b1000; req_val = 16'h9007;
        tick();
        check("rw_gnt", gnt, 4'b1000);
        tick();
        req = 4'b1001;
        rst_n = 1'b0;
        #1;
        check("rw_gnt_async", gnt, 0);
        check("rw_busy_async", busy, 0);
        check("rw_load_async", cnt_load, 0);
        check("rw_err_async", err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rw_first_gnt", gnt, 4'b0001);
        check("rw_first_val", cnt_val, 7);
        check("rw_first_load", cnt_load, 1);
        tick();
        cnt_r = 1'b1;
        tick();
        check("rw_done", done, 4'b0001);
        cnt_r = 1'b0; req = 4'b0000;
        tick();
        check("rw_rel_busy", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
